// File: rtl/nv_nvdla_reg_single_multi.sv
// Multi-group register sequencer: per-group op FSMs, consumer pointer, done counter and interrupt.
// Optional sticky error register enabled by defining NVDLA_REG_SINGLE_ERR_EN.
module nv_nvdla_reg_single_multi #(
   parameter int GROUPS = 2,
   parameter int PTR_W  = 1,
   parameter int CNT_W  = 8
) (
   input  logic                nvdla_core_clk,
   input  logic                nvdla_core_rst,
   input  logic [11:0]         reg_offset,
   input  logic [31:0]         reg_wr_data,
   input  logic                reg_wr_en,
   output logic [31:0]         reg_rd_data,
   output logic [PTR_W-1:0]    producer,
   output logic [PTR_W-1:0]    consumer,
   output logic [2*GROUPS-1:0] status,
   output logic [GROUPS-1:0]   op_en,
   output logic                op_start,
   input  logic                op_done,
   output logic                done_intr
);

   localparam logic [11:0] OFF_STATUS  = 12'h000;
   localparam logic [11:0] OFF_POINTER = 12'h004;
   localparam logic [11:0] OFF_OPEN    = 12'h008;
   localparam logic [11:0] OFF_DCNT    = 12'h00C;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PENDING = 2'd2
   } grp_state_t;

   grp_state_t       state [GROUPS];
   logic [CNT_W-1:0] done_cnt;
   logic             running_any;
   logic             done_ok;
   logic             en_wr;
   logic             ptr_wr;
   logic             cnt_wr;
   logic [PTR_W-1:0] consumer_nxt;
   logic             unused_wr_bits;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign en_wr          = reg_wr_en && (reg_offset == OFF_OPEN);
   assign ptr_wr         = reg_wr_en && (reg_offset == OFF_POINTER);
   assign cnt_wr         = reg_wr_en && (reg_offset == OFF_DCNT);
   assign done_ok        = op_done && running_any;
   assign consumer_nxt   = (consumer == PTR_W'(GROUPS - 1)) ? '0 : consumer + PTR_W'(1);
   assign unused_wr_bits = ^reg_wr_data;

   always_comb begin
      running_any = 1'b0;
      op_en       = '0;
      status      = '0;
      for (int g = 0; g < GROUPS; g++) begin
         running_any      = running_any | (state[g] == ST_RUNNING);
         op_en[g]         = (state[g] != ST_IDLE);
         status[2*g +: 2] = state[g];
      end
   end

   // All transitions sample the pre-edge state, so a done and a re-enable of the same group never chain.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         for (int g = 0; g < GROUPS; g++) state[g] <= ST_IDLE;
         consumer  <= '0;
         producer  <= '0;
         done_cnt  <= '0;
         op_start  <= 1'b0;
         done_intr <= 1'b0;
      end else begin
         op_start  <= 1'b0;
         done_intr <= done_ok;
         for (int g = 0; g < GROUPS; g++) begin
            case (state[g])
               ST_IDLE:    if (en_wr && reg_wr_data[g]) state[g] <= ST_PENDING;
               ST_PENDING: if ((consumer == PTR_W'(g)) && !running_any) begin
                  state[g] <= ST_RUNNING;
                  op_start <= 1'b1;
               end
               ST_RUNNING: if (op_done) state[g] <= ST_IDLE;
               default:    state[g] <= ST_IDLE;
            endcase
         end
         if (done_ok) consumer <= consumer_nxt;
         if (cnt_wr)       done_cnt <= '0;
         else if (done_ok) done_cnt <= sat_inc(done_cnt);
         if (ptr_wr) producer <= reg_wr_data[PTR_W-1:0];
      end
   end

`ifdef NVDLA_REG_SINGLE_ERR_EN
   localparam logic [11:0] OFF_ERR = 12'h010;

   logic [1:0] err;
   logic       err_wr;
   logic       dbl_en;

   assign err_wr = reg_wr_en && (reg_offset == OFF_ERR);
   assign dbl_en = en_wr && |(reg_wr_data[GROUPS-1:0] & op_en);

   // Set events are OR-ed in after the clear mask so they win a same-cycle clear.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         err <= 2'b00;
      end else begin
         err <= (err & ~(err_wr ? reg_wr_data[1:0] : 2'b00)) | {dbl_en, op_done && !running_any};
      end
   end
`endif

   always_comb begin
      reg_rd_data = '0;
      case (reg_offset)
         OFF_STATUS: begin
            for (int g = 0; g < GROUPS; g++) reg_rd_data[8*g +: 2] = state[g];
         end
         OFF_POINTER: begin
            reg_rd_data[PTR_W-1:0]  = producer;
            reg_rd_data[16 +: PTR_W] = consumer;
         end
         OFF_OPEN: reg_rd_data[GROUPS-1:0] = op_en;
         OFF_DCNT: reg_rd_data[CNT_W-1:0]  = done_cnt;
`ifdef NVDLA_REG_SINGLE_ERR_EN
         OFF_ERR:  reg_rd_data[1:0]        = err;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nv_nvdla_reg_single_multi.sv
// Scoreboard bench for nv_nvdla_reg_single_multi: a 2-group and a 4-group instance driven by directed vectors.
module tb_nv_nvdla_reg_single_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] reg_offset = '0;
   logic [31:0] reg_wr_data = '0;
   logic        wr_en = 1'b0;
   logic        wr_en4 = 1'b0;
   logic        op_done = 1'b0;
   logic        op_done4 = 1'b0;

   logic [31:0] rd_data, rd_data4;
   logic [0:0]  producer, consumer;
   logic [1:0]  producer4, consumer4;
   logic [3:0]  status;
   logic [7:0]  status4;
   logic [1:0]  op_en;
   logic [3:0]  op_en4;
   logic        op_start, op_start4, done_intr, done_intr4;

   nv_nvdla_reg_single_multi #(.GROUPS(2), .PTR_W(1), .CNT_W(8)) dut (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg_offset(reg_offset),
      .reg_wr_data(reg_wr_data), .reg_wr_en(wr_en), .reg_rd_data(rd_data),
      .producer(producer), .consumer(consumer), .status(status), .op_en(op_en),
      .op_start(op_start), .op_done(op_done), .done_intr(done_intr));

   nv_nvdla_reg_single_multi #(.GROUPS(4), .PTR_W(2), .CNT_W(8)) dut4 (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg_offset(reg_offset),
      .reg_wr_data(reg_wr_data), .reg_wr_en(wr_en4), .reg_rd_data(rd_data4),
      .producer(producer4), .consumer(consumer4), .status(status4), .op_en(op_en4),
      .op_start(op_start4), .op_done(op_done4), .done_intr(done_intr4));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } item_t;

   item_t sb[$];
   logic  chk_req = 1'b0;
   int    vectors = 0;
   int    miscompares = 0;

   // sel: 0 rd_data, 1 {op_start,done_intr}, 8 rd_data4, 9 {op_start4,done_intr4}, 10 consumer4
   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return rd_data;
         1:       return {30'd0, op_start, done_intr};
         8:       return rd_data4;
         9:       return {30'd0, op_start4, done_intr4};
         10:      return {30'd0, consumer4};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      item_t       it;
      logic [31:0] act;
      if (chk_req) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got check request, expected a queued item");
         end else begin
            it  = sb.pop_front();
            act = observe(it.sel);
            if (act !== it.exp) begin
               miscompares++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      wr_en    = 1'b0;
      wr_en4   = 1'b0;
      op_done  = 1'b0;
      op_done4 = 1'b0;
      chk_req  = 1'b0;
   endtask

   task automatic wr(input logic [11:0] off, input logic [31:0] d);
      reg_offset  = off;
      reg_wr_data = d;
      wr_en       = 1'b1;
      step();
   endtask

   task automatic wr4(input logic [11:0] off, input logic [31:0] d);
      reg_offset  = off;
      reg_wr_data = d;
      wr_en4      = 1'b1;
      step();
   endtask

   task automatic chk(input int sel, input logic [11:0] off, input logic [31:0] exp, input string name);
      item_t it;
      it.name = name;
      it.sel  = sel;
      it.exp  = exp;
      reg_offset = off;
      chk_req    = 1'b1;
      sb.push_back(it);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      chk(0, 12'h000, 32'h0, "rst_status");
      chk(0, 12'h004, 32'h0, "rst_pointer");
      chk(0, 12'h008, 32'h0, "rst_op_en");
      chk(0, 12'h00C, 32'h0, "rst_cnt");
      chk(1, 12'h000, 32'h0, "rst_pulses");
      chk(8, 12'h004, 32'h0, "rst4_pointer");

      wr(12'h004, 32'hFFFF_FFFF);
      chk(0, 12'h004, 32'h0000_0001, "ptr_rw");
      chk(0, 12'h000, 32'h0, "ptr_status");

      // single op on g0 with producer left at 1
      wr(12'h008, 32'h1);
      chk(0, 12'h000, 32'h2, "pend_g0");
      chk(1, 12'h000, 32'h2, "start_pulse");
      chk(1, 12'h000, 32'h0, "start_once");
      chk(0, 12'h000, 32'h1, "run_g0");
      chk(0, 12'h008, 32'h1, "op_en_g0");
      wr(12'h004, 32'h0);
      op_done = 1'b1;
      step();
      chk(1, 12'h000, 32'h1, "intr_pulse");
      chk(1, 12'h000, 32'h0, "intr_once");
      chk(0, 12'h000, 32'h0, "idle_g0");
      chk(0, 12'h004, 32'h0001_0000, "cons_adv");
      chk(0, 12'h00C, 32'h1, "cnt1");

      wr(12'h008, 32'h2);
      step();
      chk(0, 12'h000, 32'h100, "run_g1");
      op_done = 1'b1;
      step();
      chk(0, 12'h004, 32'h0, "cons_wrap");
      chk(0, 12'h00C, 32'h2, "cnt2");

      // both groups queued; done collides with a re-enable of the running group
      wr(12'h008, 32'h3);
      chk(0, 12'h000, 32'h202, "pend_both");
      chk(1, 12'h000, 32'h2, "start_g0");
      chk(0, 12'h000, 32'h201, "g0_run_g1_pend");
      op_done = 1'b1;
      wr(12'h008, 32'h1);
      chk(0, 12'h000, 32'h200, "done_ignores_en");
      chk(1, 12'h000, 32'h2, "start_g1");
      chk(0, 12'h000, 32'h100, "run_g1b");
      op_done = 1'b1;
      step();
      chk(1, 12'h000, 32'h1, "intr_g1");
      chk(0, 12'h004, 32'h0, "cons_wrap2");
      chk(0, 12'h00C, 32'h4, "cnt4");

      op_done = 1'b1;
      step();
      chk(1, 12'h000, 32'h0, "spur_no_intr");
      chk(0, 12'h00C, 32'h4, "spur_cnt");
      chk(0, 12'h000, 32'h0, "spur_status");
      chk(0, 12'h004, 32'h0, "spur_cons");

      wr(12'h100, 32'hFFFF_FFFF);
      wr(12'h000, 32'hFFFF_FFFF);
      chk(0, 12'h100, 32'h0, "undef_rd");
      chk(0, 12'h000, 32'h0, "status_ro");

      wr(12'h00C, 32'h1234_5678);
      chk(0, 12'h00C, 32'h0, "cnt_clear");

      for (int i = 0; i < 300; i++) begin
         wr(12'h008, (i % 2 == 0) ? 32'h1 : 32'h2);
         step();
         op_done = 1'b1;
         step();
      end
      chk(0, 12'h00C, 32'hFF, "cnt_sat");
      chk(0, 12'h004, 32'h0, "sat_cons");

      wr(12'h008, 32'h1);
      step();
      op_done = 1'b1;
      wr(12'h00C, 32'h0);
      chk(0, 12'h00C, 32'h0, "clr_wins");
      chk(0, 12'h004, 32'h0001_0000, "clr_cons");

`ifdef NVDLA_REG_SINGLE_ERR_EN
      wr(12'h010, 32'h3);
      chk(0, 12'h010, 32'h0, "err_clr0");
      op_done = 1'b1;
      step();
      chk(0, 12'h010, 32'h1, "err_spur");
      wr(12'h010, 32'h1);
      chk(0, 12'h010, 32'h0, "err_w1c");
      wr(12'h008, 32'h2);
      wr(12'h008, 32'h2);
      chk(0, 12'h010, 32'h2, "err_dbl");
      op_done = 1'b1;
      step();
      wr(12'h010, 32'h2);
      chk(0, 12'h010, 32'h0, "err_dbl_clr");
      op_done = 1'b1;
      wr(12'h010, 32'h1);
      chk(0, 12'h010, 32'h1, "err_set_wins");
`else
      wr(12'h010, 32'hFFFF_FFFF);
      op_done = 1'b1;
      step();
      chk(0, 12'h010, 32'h0, "err_absent");
`endif

      // reset while an op is running
      wr(12'h008, 32'h3);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk(1, 12'h000, 32'h0, "rst_mid_pulse");
      chk(0, 12'h000, 32'h0, "rst_mid_status");
      op_done = 1'b1;
      step();
      chk(1, 12'h000, 32'h0, "rst_mid_no_intr");
      chk(0, 12'h00C, 32'h0, "rst_mid_cnt");

      // four-group rotation
      wr4(12'h008, 32'hF);
      chk(8, 12'h000, 32'h0202_0202, "g4_pend_all");
      for (int j = 0; j < 4; j++) begin
         chk(10, 12'h000, 32'(j), "g4_cons");
         op_done4 = 1'b1;
         step();
         chk(9, 12'h000, 32'h1, "g4_intr");
      end
      chk(10, 12'h000, 32'h0, "g4_cons_wrap");
      chk(8, 12'h000, 32'h0, "g4_status_end");
      chk(8, 12'h00C, 32'h4, "g4_cnt");

      step();
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: got %0d items, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
